pc_next_address_unit: RTL
=========================

// Module: pc_next_address_unit
// PURPOSE
//   Producer side of the program-counter interface: computes next_address that the
//   program counter latches each gated clock edge, from the current PCin and the
//   decoded control-flow op. Owns the internal halt request (halt) fed to the PC
//   clock wrapper, a small return-address stack (RAS) and the halt/resume FSM.
//   Runs on the free-running clkext so it can leave HALTED while the PC clock is gated.
// PARAMETERS
//   RESET_VECTOR  32'h0000_0000  next_address driven while reset is high
//   RAS_DEPTH     4              return-address stack entries (power of 2, >=2)
// PORTS
//   clkext         in   1   free-running clock; all state updates on posedge
//   reset          in   1   synchronous, active-high
//   PCin           in   32  current PC from program counter
//   instr_valid    in   1   op/cond/imm/reg_target valid this cycle
//   ctl_op         in   3   0 SEQ,1 BRANCH,2 JUMP,3 JUMPR,4 CALL,5 RET,6 HALT,7 rsvd(=SEQ)
//   cond           in   1   branch condition (BRANCH only)
//   imm            in   32  signed byte offset (BRANCH) / absolute target (JUMP, CALL)
//   reg_target     in   32  register target (JUMPR)
//   mem_ready      in   1   0 = fetch stall, hold PC
//   resume         in   1   pulse: leave HALTED
//   next_address   out  32  address for program counter (combinational)
//   halt           out  1   registered internal halt request to clock wrapper
//   ras_overflow   out  1   sticky: CALL pushed onto full RAS
//   ras_underflow  out  1   sticky: RET popped empty RAS
// BEHAVIOUR
//   - Reset (sync): state=RUN, halt=0, RAS empty (count=0, ptr=0), both sticky flags 0;
//     next_address=RESET_VECTOR combinationally while reset=1. Reset mid-HALTED or
//     mid-stall aborts immediately; no pending op survives.
//   - FSM: RUN, HALTED. halt = (state==HALTED), registered.
//     RUN -> HALTED: instr_valid & ctl_op==HALT & mem_ready. HALTED -> RUN: resume.
//     resume in RUN ignored. HALT & resume same cycle in RUN: enter HALTED.
//   - next_address priority (all arithmetic mod 2^32, wrap silently):
//     1 reset -> RESET_VECTOR; 2 HALTED -> PCin; 3 !mem_ready -> PCin (no RAS/FSM change);
//     4 !instr_valid -> PCin+4; 5 by op:
//       SEQ/rsvd PCin+4; BRANCH cond ? PCin+imm : PCin+4; JUMP imm; JUMPR reg_target;
//       CALL imm, push PCin+4; RET pop top if count>0 else PCin+4;
//       HALT PCin+4 (PC advances past HALT on the edge halt rises).
//   - Latency: next_address 0 cycles; RAS, FSM, flags update at next clkext edge.
//   - RAS: circular, count saturates at RAS_DEPTH. Push on full overwrites oldest
//     entry, count stays RAS_DEPTH, sets ras_overflow. Pop on empty: no change,
//     sets ras_underflow. Flags clear only on reset. Push/pop only when qualified
//     (instr_valid & mem_ready & state==RUN & !reset).
//   - Ops arriving while HALTED or stalled are dropped; producer must re-present.
// TESTING
//   - Reset: reset=1 2 cycles -> next_address=RESET_VECTOR, halt=0, flags 0; release,
//     PCin=0, SEQ -> next_address=4.
//   - Branch: PCin=0x100, BRANCH imm=-8, cond=1 -> 0xF8; cond=0 -> 0x104;
//     PCin=0xFFFF_FFFC SEQ -> 0x0 (wrap).
//   - RAS: PCin=0x10 CALL imm=0x200 -> 0x200; later RET -> 0x14; RAS_DEPTH+1 CALLs then
//     RAS_DEPTH+1 RETs -> newest RAS_DEPTH addresses LIFO, ras_overflow=1, last RET
//     -> PCin+4 and ras_underflow=1.
//   - Halt: PCin=0x40 HALT -> next_address=0x44, halt=1 next edge, holds PCin while
//     HALTED, CALL ignored (RAS unchanged); resume pulse -> halt=0 next edge.
//   - Stall: mem_ready=0 with CALL at PCin=0x80 -> next_address=0x80, RAS count
//     unchanged; mem_ready=1 -> 0x200-style target and push 0x84.
//   - Reset while HALTED with 2 RAS entries -> halt=0, RET -> PCin+4, underflow=1.

Source files
------------

// File: rtl/pc_next_address_unit_if.sv
// Program-counter next-address bus: control-flow request from the fetch side,
// next address and status back from the next-address unit.
interface pc_next_address_unit_if;
    logic [31:0] PCin;
    logic        instr_valid;
    logic [2:0]  ctl_op;
    logic        cond;
    logic [31:0] imm;
    logic [31:0] reg_target;
    logic        mem_ready;
    logic        resume;
    logic [31:0] next_address;
    logic        halt;
    logic        ras_overflow;
    logic        ras_underflow;

    modport master (
        output PCin, instr_valid, ctl_op, cond, imm, reg_target, mem_ready, resume,
        input  next_address, halt, ras_overflow, ras_underflow
    );

    modport slave (
        input  PCin, instr_valid, ctl_op, cond, imm, reg_target, mem_ready, resume,
        output next_address, halt, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_next_address_unit.sv
// Next-address generator for the program counter: control-flow decode, return-address
// stack and the halt/resume FSM, clocked by the free-running clkext.
module pc_next_address_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic                   clkext,
    input  logic                   reset,
    pc_next_address_unit_if.slave  bus
);
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        OP_SEQ    = 3'd0,
        OP_BRANCH = 3'd1,
        OP_JUMP   = 3'd2,
        OP_JUMPR  = 3'd3,
        OP_CALL   = 3'd4,
        OP_RET    = 3'd5,
        OP_HALT   = 3'd6,
        OP_RSVD   = 3'd7
    } ctl_op_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    state_e             state_r;
    state_e             state_next_s;
    logic               halt_r;
    logic [31:0]        ras_mem_r [RAS_DEPTH];
    logic [PTR_W-1:0]   ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               ovf_r;
    logic               unf_r;

    ctl_op_e            op_s;
    logic [31:0]        seq_s;
    logic [31:0]        top_s;
    logic [31:0]        next_s;
    logic               push_s;
    logic               pop_s;
    logic               halt_req_s;

    assign op_s  = ctl_op_e'(bus.ctl_op);
    assign seq_s = bus.PCin + 32'd4;
    assign top_s = ras_mem_r[ptr_r - PTR_W'(1)];

    // Next-address selection; push/pop/halt requests only fire on a qualified op.
    always_comb begin
        next_s     = seq_s;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        halt_req_s = 1'b0;
        if (reset) begin
            next_s = RESET_VECTOR;
        end else if (state_r == ST_HALTED) begin
            next_s = bus.PCin;
        end else if (!bus.mem_ready) begin
            next_s = bus.PCin;
        end else if (!bus.instr_valid) begin
            next_s = seq_s;
        end else begin
            case (op_s)
                OP_BRANCH: begin
                    if (bus.cond) begin
                        next_s = bus.PCin + bus.imm;
                    end else begin
                        next_s = seq_s;
                    end
                end
                OP_JUMP:   next_s = bus.imm;
                OP_JUMPR:  next_s = bus.reg_target;
                OP_CALL: begin
                    next_s = bus.imm;
                    push_s = 1'b1;
                end
                OP_RET: begin
                    pop_s = 1'b1;
                    if (count_r != {CNT_W{1'b0}}) begin
                        next_s = top_s;
                    end else begin
                        next_s = seq_s;
                    end
                end
                OP_HALT: begin
                    next_s     = seq_s;
                    halt_req_s = 1'b1;
                end
                default:   next_s = seq_s;
            endcase
        end
    end

    // Halt/resume next-state logic; resume in RUN has no effect.
    always_comb begin
        state_next_s = state_r;
        if (reset) begin
            state_next_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (halt_req_s) begin
                        state_next_s = ST_HALTED;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_HALTED: begin
                    if (bus.resume) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_HALTED;
                    end
                end
                default: state_next_s = ST_RUN;
            endcase
        end
    end

    // FSM state and registered halt request.
    always_ff @(posedge clkext) begin
        if (reset) begin
            state_r <= ST_RUN;
            halt_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            halt_r  <= (state_next_s == ST_HALTED);
        end
    end

    // Circular return-address stack: a push on full overwrites the oldest slot.
    always_ff @(posedge clkext) begin
        if (reset) begin
            ptr_r   <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else if (push_s) begin
            ras_mem_r[ptr_r] <= seq_s;
            ptr_r            <= ptr_r + PTR_W'(1);
            if (count_r == DEPTH_C) begin
                ovf_r <= 1'b1;
            end else begin
                count_r <= count_r + CNT_W'(1);
            end
        end else if (pop_s) begin
            if (count_r != {CNT_W{1'b0}}) begin
                ptr_r   <= ptr_r - PTR_W'(1);
                count_r <= count_r - CNT_W'(1);
            end else begin
                unf_r <= 1'b1;
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign bus.next_address  = next_s;
    assign bus.halt          = halt_r;
    assign bus.ras_overflow  = ovf_r;
    assign bus.ras_underflow = unf_r;
endmodule
